// File: rtl/mips_alu_pkg.sv
// Shared MIPS ALU definitions: op codes, HI/LO interlock state and op-class helpers.
package mips_alu_pkg;

   localparam logic [5:0] OP_MULT  = 6'b011000;
   localparam logic [5:0] OP_MULTU = 6'b011001;
   localparam logic [5:0] OP_DIV   = 6'b011010;
   localparam logic [5:0] OP_DIVU  = 6'b011011;
   localparam logic [5:0] OP_MTHI  = 6'b010001;
   localparam logic [5:0] OP_MTLO  = 6'b010011;
   localparam logic [5:0] OP_MFHI  = 6'b010000;
   localparam logic [5:0] OP_MFLO  = 6'b010010;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      BUSY  = 2'd2
   } hilo_state_t;

   function automatic logic is_md(input logic [5:0] op);
      return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
   endfunction

   function automatic logic is_hilo(input logic [5:0] op);
      return is_md(op) || (op == OP_MTHI) || (op == OP_MTLO) ||
             (op == OP_MFHI) || (op == OP_MFLO);
   endfunction

endpackage

// File: rtl/hi_lo_register_unit.sv
// Architectural HI/LO register pair with the interlock that tracks a multiply/divide
// through the ALU stall window and holds off HI/LO accesses until the result lands.
module hi_lo_register_unit
   import mips_alu_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int ARM_WAIT = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [5:0]       op,
   input  logic             op_valid,
   input  logic [WIDTH-1:0] mt_data,
   input  logic [WIDTH-1:0] alu_hi,
   input  logic [WIDTH-1:0] alu_lo,
   input  logic             alu_stall,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic [WIDTH-1:0] mf_data,
   output logic             mf_valid,
   output logic             stall_out,
   output logic             busy
);

   localparam int CW = (ARM_WAIT > 1) ? $clog2(ARM_WAIT) : 1;
   localparam logic [CW-1:0] ARM_LAST = CW'(ARM_WAIT - 1);

   hilo_state_t      r_state;
   logic [CW-1:0]    r_count;
   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;
   logic [WIDTH-1:0] r_mfData;
   logic             r_mfValid;
   logic             w_stall;

   // Any HI/LO op arriving outside IDLE waits, including the completion cycle itself.
   assign w_stall = op_valid && (r_state != IDLE) && is_hilo(op);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= IDLE;
         r_count   <= '0;
         r_hi      <= '0;
         r_lo      <= '0;
         r_mfData  <= '0;
         r_mfValid <= 1'b0;
      end else begin
         r_mfValid <= 1'b0;
         case (r_state)
            IDLE: begin
               if (op_valid) begin
                  if (is_md(op)) begin
                     r_state <= ARMED;
                     r_count <= '0;
                  end else begin
                     case (op)
                        OP_MTHI: r_hi <= mt_data;
                        OP_MTLO: r_lo <= mt_data;
                        OP_MFHI: begin
                           r_mfData  <= r_hi;
                           r_mfValid <= 1'b1;
                        end
                        OP_MFLO: begin
                           r_mfData  <= r_lo;
                           r_mfValid <= 1'b1;
                        end
                        default: ;
                     endcase
                  end
               end
            end
            // If the ALU never raises its stall, the result was ready immediately.
            ARMED: begin
               if (alu_stall) begin
                  r_state <= BUSY;
               end else if (r_count == ARM_LAST) begin
                  r_hi    <= alu_hi;
                  r_lo    <= alu_lo;
                  r_state <= IDLE;
               end else begin
                  r_count <= r_count + 1'b1;
               end
            end
            BUSY: begin
               if (!alu_stall) begin
                  r_hi    <= alu_hi;
                  r_lo    <= alu_lo;
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign hi        = r_hi;
   assign lo        = r_lo;
   assign mf_data   = r_mfData;
   assign mf_valid  = r_mfValid;
   assign stall_out = w_stall;
   assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_hi_lo_register_unit.sv
// Directed bench for hi_lo_register_unit: MT/MF access, multiply/divide capture paths,
// interlock stalls and asynchronous reset during an in-flight operation.
module tb_hi_lo_register_unit;
   import mips_alu_pkg::*;

   localparam logic [5:0] OP_ADDU = 6'b100001;

   logic        clk = 1'b0;
   logic        reset;
   logic [5:0]  op;
   logic        op_valid;
   logic [31:0] mt_data;
   logic [31:0] alu_hi;
   logic [31:0] alu_lo;
   logic        alu_stall;
   logic [31:0] hi;
   logic [31:0] lo;
   logic [31:0] mf_data;
   logic        mf_valid;
   logic        stall_out;
   logic        busy;

   int checkCount = 0;
   int errorCount = 0;

   hi_lo_register_unit #(.WIDTH(32), .ARM_WAIT(2)) dut (
      .clk       (clk),
      .reset     (reset),
      .op        (op),
      .op_valid  (op_valid),
      .mt_data   (mt_data),
      .alu_hi    (alu_hi),
      .alu_lo    (alu_lo),
      .alu_stall (alu_stall),
      .hi        (hi),
      .lo        (lo),
      .mf_data   (mf_data),
      .mf_valid  (mf_valid),
      .stall_out (stall_out),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // Compare one observed value against its hand-computed expectation.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
      end
   endtask

   // Drive the op interface; called 1ns after a rising edge, then settles combinational logic.
   task automatic applyStimulus(input logic [5:0] o, input logic v, input logic [31:0] mt);
      op       = o;
      op_valid = v;
      mt_data  = mt;
      #1;
   endtask

   // Advance to just after the next rising edge.
   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset     = 1'b1;
      op        = 6'd0;
      op_valid  = 1'b0;
      mt_data   = '0;
      alu_hi    = '0;
      alu_lo    = '0;
      alu_stall = 1'b0;
      cycle();
      cycle();
      checkOutput("reset hi", hi, 32'h0);
      checkOutput("reset lo", lo, 32'h0);
      checkOutput("reset mf_valid", {31'd0, mf_valid}, 32'd0);
      checkOutput("reset busy", {31'd0, busy}, 32'd0);
      reset = 1'b0;

      // MFHI / MFLO after reset
      applyStimulus(OP_MFHI, 1'b1, 32'h0);
      checkOutput("mfhi stall_out", {31'd0, stall_out}, 32'd0);
      cycle();
      checkOutput("mfhi mf_valid", {31'd0, mf_valid}, 32'd1);
      checkOutput("mfhi mf_data", mf_data, 32'h0);
      applyStimulus(OP_MFLO, 1'b1, 32'h0);
      checkOutput("mflo stall_out", {31'd0, stall_out}, 32'd0);
      cycle();
      checkOutput("mflo mf_valid", {31'd0, mf_valid}, 32'd1);
      checkOutput("mflo mf_data", mf_data, 32'h0);
      applyStimulus(6'd0, 1'b0, 32'h0);
      cycle();
      checkOutput("mf_valid pulse ends", {31'd0, mf_valid}, 32'd0);

      // MTHI then MTLO then MFLO
      applyStimulus(OP_MTHI, 1'b1, 32'hDEADBEEF);
      cycle();
      checkOutput("mthi hi", hi, 32'hDEADBEEF);
      checkOutput("mthi lo untouched", lo, 32'h0);
      applyStimulus(OP_MTLO, 1'b1, 32'h12345678);
      cycle();
      checkOutput("mtlo lo", lo, 32'h12345678);
      checkOutput("mtlo hi untouched", hi, 32'hDEADBEEF);
      applyStimulus(OP_MFLO, 1'b1, 32'h0);
      cycle();
      checkOutput("mflo after mt", mf_data, 32'h12345678);
      checkOutput("mflo after mt valid", {31'd0, mf_valid}, 32'd1);
      applyStimulus(6'd0, 1'b0, 32'h0);
      cycle();

      // MULT with a 5-cycle ALU stall and an MFHI waiting in BUSY
      applyStimulus(OP_MULT, 1'b1, 32'h0);
      checkOutput("mult issue stall_out", {31'd0, stall_out}, 32'd0);
      cycle();
      checkOutput("mult armed busy", {31'd0, busy}, 32'd1);
      alu_stall = 1'b1;
      applyStimulus(6'd0, 1'b0, 32'h0);
      cycle();
      applyStimulus(OP_MFHI, 1'b1, 32'h0);
      for (int i = 0; i < 4; i++) begin
         checkOutput($sformatf("mult busy stall_out %0d", i), {31'd0, stall_out}, 32'd1);
         checkOutput($sformatf("mult busy hi %0d", i), hi, 32'hDEADBEEF);
         cycle();
      end
      alu_stall = 1'b0;
      alu_hi    = 32'hFFFFFFFF;
      alu_lo    = 32'hFFFFFFFE;
      #1;
      checkOutput("completion cycle stall_out", {31'd0, stall_out}, 32'd1);
      cycle();
      checkOutput("mult capture hi", hi, 32'hFFFFFFFF);
      checkOutput("mult capture lo", lo, 32'hFFFFFFFE);
      checkOutput("mult capture busy", {31'd0, busy}, 32'd0);
      checkOutput("mf not yet accepted", {31'd0, mf_valid}, 32'd0);
      checkOutput("mfhi released stall_out", {31'd0, stall_out}, 32'd0);
      cycle();
      checkOutput("mfhi after mult valid", {31'd0, mf_valid}, 32'd1);
      checkOutput("mfhi after mult data", mf_data, 32'hFFFFFFFF);
      applyStimulus(6'd0, 1'b0, 32'h0);
      cycle();

      // DIVU with alu_stall never rising: zero-latency completion after ARM_WAIT cycles
      alu_hi = 32'h1;
      alu_lo = 32'h7;
      applyStimulus(OP_DIVU, 1'b1, 32'h0);
      cycle();
      applyStimulus(6'd0, 1'b0, 32'h0);
      checkOutput("divu armed busy", {31'd0, busy}, 32'd1);
      cycle();
      checkOutput("divu still armed", {31'd0, busy}, 32'd1);
      checkOutput("divu no early capture", lo, 32'hFFFFFFFE);
      cycle();
      checkOutput("divu done busy", {31'd0, busy}, 32'd0);
      checkOutput("divu lo", lo, 32'h7);
      checkOutput("divu hi", hi, 32'h1);

      // Non-HI/LO op during BUSY
      applyStimulus(OP_MULT, 1'b1, 32'h0);
      cycle();
      alu_stall = 1'b1;
      applyStimulus(6'd0, 1'b0, 32'h0);
      cycle();
      applyStimulus(OP_ADDU, 1'b1, 32'h55555555);
      checkOutput("addu busy stall_out", {31'd0, stall_out}, 32'd0);
      cycle();
      checkOutput("addu hi unchanged", hi, 32'h1);
      checkOutput("addu lo unchanged", lo, 32'h7);
      checkOutput("addu still busy", {31'd0, busy}, 32'd1);
      applyStimulus(6'd0, 1'b0, 32'h0);

      // Asynchronous reset while BUSY abandons the operation
      reset = 1'b1;
      #1;
      checkOutput("async reset hi", hi, 32'h0);
      checkOutput("async reset busy", {31'd0, busy}, 32'd0);
      alu_stall = 1'b0;
      alu_hi    = 32'hAAAA0000;
      alu_lo    = 32'h0000AAAA;
      cycle();
      reset = 1'b0;
      cycle();
      checkOutput("post reset hi", hi, 32'h0);
      checkOutput("post reset lo", lo, 32'h0);
      checkOutput("post reset busy", {31'd0, busy}, 32'd0);
      applyStimulus(OP_MFHI, 1'b1, 32'h0);
      checkOutput("post reset stall_out", {31'd0, stall_out}, 32'd0);
      cycle();
      checkOutput("post reset mfhi", mf_data, 32'h0);
      applyStimulus(6'd0, 1'b0, 32'h0);
      cycle();

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
